// File: rtl/int32_to_int8_compressor.sv
// Block-scaled int32 -> int8 weight compressor: buffers BLOCK_LEN words, picks one power-of-two
// shift per block, then streams rounded/saturated int8 words with a one-hot scale word.
module int32_to_int8_compressor #(
  parameter int BLOCK_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [31:0] out_scale,
  output logic        out_last
);

  localparam int AW = $clog2(BLOCK_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {COLLECT, SELECT, EMIT} state_t;

  state_t             state;
  logic [AW-1:0]      wr_cnt;
  logic [AW-1:0]      rd_cnt;
  logic [AW-1:0]      rd_nxt;
  logic signed [31:0] run_max;
  logic signed [31:0] run_min;
  logic signed [31:0] din;
  logic [4:0]         sh;
  logic [4:0]         sh_sel;
  logic               take;
  logic               give;
  logic signed [31:0] buffer [BLOCK_LEN];

  // Smallest shift in {0,1,2,4,8,16} that brings both extremes into int8 range.
  function automatic logic [4:0] pick_sh(input logic signed [31:0] mx, input logic signed [31:0] mn);
    logic [4:0] r;
    logic [4:0] c;
    r = 5'd16;
    for (int i = 4; i >= 0; i--) begin
      c = (i == 0) ? 5'd0 : 5'(1 << (i - 1));
      if ((mx >>> c) <= 32'sd127 && (mn >>> c) >= -32'sd128) r = c;
    end
    return r;
  endfunction

  // Round-half-up in 33 bits so x near INT32_MAX cannot wrap, then clamp to int8.
  function automatic logic [7:0] compress(input logic signed [31:0] x, input logic [4:0] s);
    logic signed [32:0] w;
    w = {x[31], x};
    if (s != 5'd0) w = (w + (33'sd1 <<< (s - 5'd1))) >>> s;
    if (w > 33'sd127) return 8'h7F;
    else if (w < -33'sd128) return 8'h80;
    else return w[7:0];
  endfunction

  assign din    = in_data;
  assign take   = in_valid && in_ready && (state == COLLECT);
  assign give   = out_valid && out_ready && (state == EMIT);
  assign sh_sel = pick_sh(run_max, run_min);
  assign rd_nxt = rd_cnt + AW'(1);

  always_ff @(posedge clk) begin
    if (take) buffer[wr_cnt] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      run_max   <= '0;
      run_min   <= '0;
      sh        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_scale <= 32'd1;
      out_last  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          in_ready <= 1'b1;
          if (take) begin
            if (wr_cnt == '0) begin
              run_max <= din;
              run_min <= din;
            end else begin
              if (din > run_max) run_max <= din;
              if (din < run_min) run_min <= din;
            end
            if (wr_cnt == LAST_IDX) begin
              wr_cnt   <= '0;
              in_ready <= 1'b0;
              state    <= SELECT;
            end else begin
              wr_cnt <= wr_cnt + AW'(1);
            end
          end
        end
        SELECT: begin
          sh        <= sh_sel;
          out_scale <= 32'd1 << sh_sel;
          out_data  <= compress(buffer[rd_cnt], sh_sel);
          out_last  <= 1'b0;
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (give) begin
            if (out_last) begin
              rd_cnt    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= COLLECT;
            end else begin
              rd_cnt   <= rd_nxt;
              out_data <= compress(buffer[rd_nxt], sh);
              out_last <= (rd_nxt == LAST_IDX);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_int32_to_int8_compressor.sv
// Directed bench for int32_to_int8_compressor: hand-computed blocks, stalls and resets.
module tb_int32_to_int8_compressor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [31:0] out_scale;
  logic        out_last;

  int total = 0;
  int bad = 0;

  int32_to_int8_compressor #(.BLOCK_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_scale(out_scale), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_block(input logic [31:0] v[16]);
    for (int i = 0; i < 16; i++) push(v[i]);
    check("select_valid", 32'(out_valid), 32'd0);
    check("select_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pull(input logic [7:0] exp_d, input logic [31:0] exp_sc, input logic exp_last, input bit stall);
    int g;
    g = 0;
    check("emit_valid", 32'(out_valid), 32'd1);
    check("emit_data", 32'(out_data), 32'(exp_d));
    check("emit_scale", out_scale, exp_sc);
    check("emit_last", 32'(out_last), 32'(exp_last));
    check("emit_in_ready", 32'(in_ready), 32'd0);
    if (stall) begin
      while ($urandom_range(0, 1) == 0 && g < 4) begin
        out_ready = 1'b0;
        @(posedge clk); #1;
        g++;
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(exp_d));
        check("stall_last", 32'(out_last), 32'(exp_last));
        check("stall_in_ready", 32'(in_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic pull_block(input logic [7:0] e[16], input logic [31:0] sc, input bit stall);
    for (int i = 0; i < 16; i++) pull(e[i], sc, (i == 15), stall);
    check("done_valid", 32'(out_valid), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] v[16];
    logic [7:0]  e[16];

    // Reset state while rst_n is held low.
    @(posedge clk); #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_scale", out_scale, 32'd1);
    check("rst_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Partial block discarded by reset mid-collect.
    for (int i = 0; i < 5; i++) push(32'd999);
    rst_n = 1'b0;
    #2;
    check("rst_collect_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_collect_ready_next", 32'(in_ready), 32'd1);

    // All 100 -> sh=0.
    for (int i = 0; i < 16; i++) begin v[i] = 32'd100; e[i] = 8'd100; end
    push_block(v);
    pull_block(e, 32'd1, 1'b0);

    // 255/-3/200 -> sh=1; 255 rounds to 128 and saturates.
    for (int i = 0; i < 16; i++) begin v[i] = 32'd200; e[i] = 8'd100; end
    v[0] = 32'd255;        e[0] = 8'd127;
    v[1] = 32'hFFFF_FFFD;  e[1] = 8'hFF;
    push_block(v);
    pull_block(e, 32'd2, 1'b0);

    // Max 1000 -> sh=4, with random output stalls.
    for (int i = 0; i < 16; i++) begin v[i] = 32'd0; e[i] = 8'd0; end
    v[3] = 32'd1000; e[3] = 8'd63;
    push_block(v);
    pull_block(e, 32'd16, 1'b1);

    // Min -2048 -> sh=4.
    for (int i = 0; i < 16; i++) begin v[i] = 32'd5; e[i] = 8'd0; end
    v[7] = 32'hFFFF_F800; e[7] = 8'h80;
    push_block(v);
    pull_block(e, 32'd16, 1'b0);

    // INT32_MAX -> sh=16, saturated; 70000 -> 1, -100000 -> -2.
    for (int i = 0; i < 16; i++) begin v[i] = 32'd70000; e[i] = 8'd1; end
    v[0]  = 32'h7FFF_FFFF; e[0]  = 8'd127;
    v[15] = 32'hFFFE_7960; e[15] = 8'hFE;
    push_block(v);
    pull_block(e, 32'h0001_0000, 1'b1);

    // Reset after 8 outputs of a block.
    for (int i = 0; i < 16; i++) begin v[i] = 32'd100; e[i] = 8'd100; end
    push_block(v);
    for (int i = 0; i < 8; i++) pull(e[i], 32'd1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_emit_valid", 32'(out_valid), 32'd0);
    check("rst_emit_in_ready", 32'(in_ready), 32'd0);
    check("rst_emit_scale", out_scale, 32'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_emit_ready_next", 32'(in_ready), 32'd1);
    check("rst_emit_valid_next", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin v[i] = 32'd7; e[i] = 8'd7; end
    push_block(v);
    pull_block(e, 32'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int32_to_int8_compressor.md
INT32_TO_INT8_COMPRESSOR -- requirements
Module: int32_to_int8_compressor

Interface
REQ-001 Parameter BLOCK_LEN, default 16, meaning number of int32 words sharing one scale per block (power of two, 2..256).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_data valid.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  32  signed int32 weight.
REQ-007 out_valid  output  1  out_data/out_scale/out_last valid.
REQ-008 out_ready  input  1  downstream accepts output this cycle.
REQ-009 out_data  output  8  signed int8 compressed weight.
REQ-010 out_scale  output  32  one-hot scale word, equal to 1 << sh, constant across a block.
REQ-011 out_last  output  1  high on the final word of a block.

Function
REQ-012 The block SHALL implement states COLLECT, SELECT, EMIT; reset state COLLECT.
REQ-013 COLLECT: in_ready=1, out_valid=0; each in_valid&&in_ready transfer stores in_data at buffer[wr_cnt], increments wr_cnt, and updates running signed max and min.
REQ-014 COLLECT -> SELECT on the transfer of word BLOCK_LEN-1; wr_cnt wraps to 0.
REQ-015 SELECT lasts exactly one cycle, in_ready=0, out_valid=0; sh SHALL be the smallest value of {0,1,2,4,8,16} with (max >>> sh) <= 127 and (min >>> sh) >= -128; if none qualifies, sh=16.
REQ-016 SELECT -> EMIT unconditionally; out_valid SHALL be high in the first EMIT cycle, i.e. two cycles after the last input transfer.
REQ-017 EMIT: in_ready=0; out_data = sat8(round(buffer[rd_cnt], sh)); out_scale = 1 << sh; out_last = (rd_cnt == BLOCK_LEN-1).
REQ-018 round(x,0)=x; for sh>0, round(x,sh) = (x + 2^(sh-1)) >>> sh, computed in 33-bit signed arithmetic (no wrap).
REQ-019 sat8 SHALL clamp to [-128, 127].
REQ-020 rd_cnt SHALL advance only on out_valid&&out_ready; with out_ready low, out_data, out_scale, out_last SHALL hold stable.
REQ-021 EMIT -> COLLECT on the transfer with out_last=1; rd_cnt wraps to 0 and running max/min reinitialise to the next accepted word.
REQ-022 Input is never accepted while SELECT or EMIT is active (no overlap between blocks).
REQ-023 out_scale SHALL decode, by the team's int8->int32 decompressor, to the same sh, so decompress(out_data) approximates in_data.

Reset
REQ-024 On rst_n low, asynchronously: state=COLLECT, wr_cnt=0, rd_cnt=0, max/min cleared, in_ready=0 during reset and 1 from the first cycle after deassertion, out_valid=0, out_data=0, out_scale=32'd1, out_last=0.
REQ-025 Reset asserted mid-COLLECT or mid-EMIT SHALL discard the partial block; no stale word may be emitted afterwards.
REQ-026 Buffer contents need not be reset.

Verification
REQ-027 Block of 16 words all 100 -> sh=0, out_scale=1, 16 outputs of 100, out_last only on 16th.
REQ-028 Block with max 1000, others 0 -> sh=4, out_scale=16, 1000 emits 63, zeros emit 0.
REQ-029 Block with min -2048, others 5 -> sh=4, -2048 emits -128, 5 emits 0.
REQ-030 Block containing 32'h7FFFFFFF -> sh=16, out_scale=32'h00010000, that word emits 127 (saturated).
REQ-031 out_ready toggled 0/1 randomly during EMIT -> all 16 words emitted in order, outputs stable while stalled, in_ready=0 throughout EMIT.
REQ-032 rst_n pulsed low after 8 outputs of a block -> out_valid=0 immediately, in_ready=1 next cycle, next block of 16 values 7 emits sixteen 7s with sh=0.
